// File: rtl/fwd_bypass_if.sv
// Forwarding/hazard bus: D-stage issue, stage results, decode read ports and bypass results.
// The master drives issue/read/stage data; the slave (fwd_bypass_net) returns operands and stall.
interface fwd_bypass_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_STG = 3,
    parameter int NUM_RD  = 2,
    parameter int TN_W    = 2
);
    logic                             iss_wen;
    logic [ADDR_W-1:0]                iss_addr;
    logic [TN_W-1:0]                  iss_tnew;
    logic [NUM_STG-1:0][DATA_W-1:0]   stg_data;
    logic [NUM_RD-1:0][ADDR_W-1:0]    rd_addr;
    logic [NUM_RD-1:0][TN_W-1:0]      rd_tuse;
    logic [NUM_RD-1:0][DATA_W-1:0]    rd_orig;
    logic [NUM_RD-1:0][DATA_W-1:0]    fwd_data;
    logic [NUM_RD-1:0]                fwd_pend;
    logic                             stall;
    logic [31:0]                      stall_cnt;
    logic [31:0]                      fwd_cnt;

    modport master (
        output iss_wen, iss_addr, iss_tnew, stg_data, rd_addr, rd_tuse, rd_orig,
        input  fwd_data, fwd_pend, stall, stall_cnt, fwd_cnt
    );
    modport slave (
        input  iss_wen, iss_addr, iss_tnew, stg_data, rd_addr, rd_tuse, rd_orig,
        output fwd_data, fwd_pend, stall, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwd_bypass_net.sv
// Forwarding + Tnew/Tuse hazard unit: in-flight write tracker and per-read-port bypass select.
// Optional FWD_STATS_EN builds the stall/forward counters; otherwise they read as constant 0.

// Per read port: youngest matching in-flight write decides forward, pend or stall.
module fwd_bypass_port #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_STG = 3,
    parameter int TN_W    = 2
) (
    input  logic [NUM_STG:1]                vld,
    input  logic [NUM_STG:1][ADDR_W-1:0]    addr,
    input  logic [NUM_STG:1][TN_W-1:0]      tnew,
    input  logic [NUM_STG-1:0][DATA_W-1:0]  stg_data,
    input  logic [ADDR_W-1:0]               rd_addr,
    input  logic [TN_W-1:0]                 rd_tuse,
    input  logic [DATA_W-1:0]               rd_orig,
    output logic [DATA_W-1:0]               fwd_data,
    output logic                            pend,
    output logic                            stl,
    output logic                            hit
);
    logic              found;
    logic [TN_W-1:0]   w_tnew;
    logic [DATA_W-1:0] w_data;

    // Scan from stage 1 upward so the youngest writer shadows any older one,
    // even when the older one already has its result ready.
    always_comb begin
        found  = 1'b0;
        w_tnew = '0;
        w_data = '0;
        for (int k = 1; k <= NUM_STG; k++) begin
            if (!found && vld[k] && addr[k] == rd_addr && rd_addr != '0) begin
                found  = 1'b1;
                w_tnew = tnew[k];
                w_data = stg_data[k-1];
            end
        end
    end

    assign hit      = found && (w_tnew == '0);
    assign fwd_data = hit ? w_data : rd_orig;
    assign pend     = found && (w_tnew != '0) && (w_tnew <= rd_tuse);
    assign stl      = found && (w_tnew > rd_tuse);
endmodule

module fwd_bypass_net #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_STG = 3,
    parameter int NUM_RD  = 2,
    parameter int TN_W    = 2
) (
    input  logic         clk,
    input  logic         reset,
    fwd_bypass_if.slave  bus
);
    logic [NUM_STG:1]              vld_pipe;
    logic [NUM_STG:1][ADDR_W-1:0]  addr_pipe;
    logic [NUM_STG:1][TN_W-1:0]    tnew_pipe;

    logic [NUM_RD-1:0][DATA_W-1:0] port_data;
    logic [NUM_RD-1:0]             port_pend;
    logic [NUM_RD-1:0]             port_stl;
    logic [NUM_RD-1:0]             port_hit;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        fwd_bypass_port #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_STG(NUM_STG), .TN_W(TN_W)
        ) u_port (
            .vld      (vld_pipe),
            .addr     (addr_pipe),
            .tnew     (tnew_pipe),
            .stg_data (bus.stg_data),
            .rd_addr  (bus.rd_addr[p]),
            .rd_tuse  (bus.rd_tuse[p]),
            .rd_orig  (bus.rd_orig[p]),
            .fwd_data (port_data[p]),
            .pend     (port_pend[p]),
            .stl      (port_stl[p]),
            .hit      (port_hit[p])
        );
    end

    assign bus.fwd_data = port_data;
    assign bus.fwd_pend = port_pend;
    assign bus.stall    = |port_stl;

    // Stage 1 takes a bubble on stall (D replays); later stages always advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            tnew_pipe <= '0;
        end else begin
            vld_pipe[1]  <= !bus.stall && bus.iss_wen && (bus.iss_addr != '0);
            addr_pipe[1] <= bus.stall ? '0 : bus.iss_addr;
            tnew_pipe[1] <= bus.stall ? '0 : bus.iss_tnew;
            for (int k = 2; k <= NUM_STG; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                addr_pipe[k] <= addr_pipe[k-1];
                tnew_pipe[k] <= (tnew_pipe[k-1] == '0) ? '0 : tnew_pipe[k-1] - TN_W'(1);
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] fwd_q;
    logic [31:0] hit_sum;

    always_comb begin
        hit_sum = '0;
        for (int p = 0; p < NUM_RD; p++)
            hit_sum = hit_sum + 32'(port_hit[p]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            fwd_q   <= '0;
        end else begin
            stall_q <= stall_q + 32'(bus.stall);
            fwd_q   <= fwd_q + hit_sum;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.fwd_cnt   = fwd_q;
`else
    logic unused_hit;
    assign unused_hit    = ^port_hit;
    assign bus.stall_cnt = '0;
    assign bus.fwd_cnt   = '0;
`endif
endmodule
